uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that lets one of NUM_REQ byte-stream requesters own
//   the ring TX data port for a whole message. The message ends when the
//   owner's EOM_BYTE is accepted, or when the owner stays idle for
//   IDLE_TIMEOUT cycles. Each accepted byte is written to the ring one cycle
//   later as a 32-bit word {24'h0, byte}.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   req_valid  : [NUM_REQ] requester i offers a byte
//   req_data   : [8*NUM_REQ] byte of requester i in bits [8i+7:8i]
//   req_ready  : [NUM_REQ] byte of requester i accepted this cycle (combinational)
//   tx_full    : ring TX buffer cannot take a byte this cycle
//   out_we     : one-cycle write strobe to the ring data port
//   out_data   : {24'h0, byte}, valid while out_we=1, holds otherwise
//   grant      : [NUM_REQ] one-hot current owner, 0 when none
//   busy       : high whenever the FSM is not IDLE
module uart_tx_arbiter #(
  parameter int          NUM_REQ      = 3,
  parameter logic [7:0]  EOM_BYTE     = 8'h0A,
  parameter int          IDLE_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 tx_full,
  output logic                 out_we,
  output logic [31:0]          out_data,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ARB, XFER, RELEASE} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     idle_cnt_q, idle_cnt_d;
  logic                 out_we_q, out_we_d;
  logic [31:0]          out_data_q, out_data_d;

  logic [PTR_W-1:0]     gidx;
  logic [PTR_W+2:0]     byte_shift;
  logic [7:0]           acc_byte;
  logic                 accept;
  logic [2*NUM_REQ-1:0] rot_wide;
  logic [NUM_REQ-1:0]   rot_valid;
  logic                 found;
  logic [PTR_W-1:0]     pick;
  int                   nxt;

  // Only the owner, in XFER, with a byte offered and room downstream.
  assign req_ready = (state_q == XFER) ? (grant_q & req_valid & {NUM_REQ{~tx_full}})
                                       : '0;
  assign accept    = |req_ready;

  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);
  assign out_we    = out_we_q;
  assign out_data  = out_data_q;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) gidx = PTR_W'(i);
    end
    byte_shift = {gidx, 3'b000};
    acc_byte   = 8'(req_data >> byte_shift);

    // Rotate so that bit 0 is the requester at rr_ptr; the first set bit k
    // then maps back to (rr_ptr + k) mod NUM_REQ.
    rot_wide  = {req_valid, req_valid} >> rr_ptr_q;
    rot_valid = rot_wide[NUM_REQ-1:0];
    found     = 1'b0;
    pick      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot_valid[k]) begin
        found = 1'b1;
        pick  = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
    nxt = (int'(gidx) + 1) % NUM_REQ;

    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    idle_cnt_d = idle_cnt_q;
    out_we_d   = accept;
    out_data_d = accept ? {24'h0, acc_byte} : out_data_q;

    case (state_q)
      IDLE: begin
        if (|req_valid) state_d = ARB;
      end
      ARB: begin
        if (found) begin
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          state_d       = XFER;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        // An accept wins over the timeout; tx_full with the owner valid
        // simply holds the counter.
        if (accept) begin
          idle_cnt_d = '0;
          if (acc_byte == EOM_BYTE) state_d = RELEASE;
        end else if (!(|(grant_q & req_valid))) begin
          if (idle_cnt_q == CNT_W'(IDLE_TIMEOUT - 1)) begin
            idle_cnt_d = CNT_W'(IDLE_TIMEOUT);
            state_d    = RELEASE;
          end else begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
          end
        end
      end
      RELEASE: begin
        grant_d    = '0;
        rr_ptr_d   = PTR_W'(nxt);
        idle_cnt_d = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      idle_cnt_q <= '0;
      out_we_q   <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      idle_cnt_q <= idle_cnt_d;
      out_we_q   <= out_we_d;
      out_data_q <= out_data_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter (NUM_REQ=3, IDLE_TIMEOUT=10).
module tb_uart_tx_arbiter;

  localparam int NR = 3;
  localparam int TO = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic          tx_full;
  logic          out_we;
  logic [31:0]   out_data;
  logic [NR-1:0] grant;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_arbiter #(.NUM_REQ(NR), .EOM_BYTE(8'h0A), .IDLE_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_full(tx_full), .out_we(out_we),
    .out_data(out_data), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0]   vld;
    logic [8*NR-1:0] data;
    logic [NR-1:0]   rdy;
    logic            we;
    logic [7:0]      od;
    logic [NR-1:0]   gnt;
    logic            bsy;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    req_data  = '0;
    tx_full   = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int bad;

    // Each row: inputs applied, then registered outputs reflect the state
    // before this row's edge and req_ready reflects this row's inputs.
    // req_data packing is {req2, req1, req0}.
    tbl[0]  = '{3'b001, 24'h000041, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0}; // IDLE
    tbl[1]  = '{3'b001, 24'h000041, 3'b000, 1'b0, 8'h00, 3'b000, 1'b1}; // ARB
    tbl[2]  = '{3'b001, 24'h000041, 3'b001, 1'b0, 8'h00, 3'b001, 1'b1}; // accept 41
    tbl[3]  = '{3'b001, 24'h000042, 3'b001, 1'b1, 8'h41, 3'b001, 1'b1}; // accept 42
    tbl[4]  = '{3'b001, 24'h00000A, 3'b001, 1'b1, 8'h42, 3'b001, 1'b1}; // accept EOM
    tbl[5]  = '{3'b000, 24'h000000, 3'b000, 1'b1, 8'h0A, 3'b001, 1'b1}; // RELEASE
    tbl[6]  = '{3'b101, 24'h7A0011, 3'b000, 1'b0, 8'h0A, 3'b000, 1'b0}; // IDLE, rr=1
    tbl[7]  = '{3'b101, 24'h7A0011, 3'b000, 1'b0, 8'h0A, 3'b000, 1'b1}; // ARB -> req2
    tbl[8]  = '{3'b101, 24'h7A0011, 3'b100, 1'b0, 8'h0A, 3'b100, 1'b1}; // accept 7A
    tbl[9]  = '{3'b101, 24'h0A0011, 3'b100, 1'b1, 8'h7A, 3'b100, 1'b1}; // accept EOM
    tbl[10] = '{3'b101, 24'h0A0011, 3'b000, 1'b1, 8'h0A, 3'b100, 1'b1}; // RELEASE
    tbl[11] = '{3'b101, 24'h00000A, 3'b000, 1'b0, 8'h0A, 3'b000, 1'b0}; // IDLE, rr=0
    tbl[12] = '{3'b101, 24'h00000A, 3'b000, 1'b0, 8'h0A, 3'b000, 1'b1}; // ARB -> req0
    tbl[13] = '{3'b101, 24'h00000A, 3'b001, 1'b0, 8'h0A, 3'b001, 1'b1}; // accept EOM
    tbl[14] = '{3'b000, 24'h000000, 3'b000, 1'b1, 8'h0A, 3'b001, 1'b1}; // RELEASE
    tbl[15] = '{3'b000, 24'h000000, 3'b000, 1'b0, 8'h0A, 3'b000, 1'b0}; // IDLE, rr=1

    rst = 1'b1;
    req_valid = '0;
    req_data  = '0;
    tx_full   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 32'(out_we), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      req_valid = tbl[i].vld;
      req_data  = tbl[i].data;
      #1;
      chk($sformatf("row%0d_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
      chk($sformatf("row%0d_we", i),    32'(out_we),    32'(tbl[i].we));
      chk($sformatf("row%0d_data", i),  out_data,       {24'h0, tbl[i].od});
      chk($sformatf("row%0d_grant", i), 32'(grant),     32'(tbl[i].gnt));
      chk($sformatf("row%0d_busy", i),  32'(busy),      32'(tbl[i].bsy));
      step();
    end

    // Idle timeout on req1 (rr_ptr is 1 here).
    req_valid = 3'b010;
    req_data  = 24'h003100;
    step();
    step();
    chk("to_grant", 32'(grant), 32'b010);
    step();
    chk("to_we", 32'(out_we), 32'd1);
    chk("to_data", out_data, 32'h31);
    req_valid = '0;
    n = 0;
    while (grant != 0 && n < 100) begin
      step();
      n++;
      if (n == TO) chk("to_release_busy", 32'(busy), 32'd1);
    end
    // RELEASE is entered on the edge the counter reaches TO; grant drops one edge later.
    chk("to_cycles", 32'(n), 32'(TO + 1));
    req_valid = 3'b111;
    step();
    step();
    chk("to_next_rr2", 32'(grant), 32'b100);

    // Long tx_full stall with valid high, then drop/raise valid before timeout.
    do_reset();
    req_valid = 3'b001;
    req_data  = 24'h00005A;
    tx_full   = 1'b1;
    step();
    step();
    chk("stall_grant", 32'(grant), 32'b001);
    chk("stall_ready", 32'(req_ready), 32'd0);
    bad = 0;
    repeat (1000) begin
      step();
      if (out_we !== 1'b0 || grant !== 3'b001 || req_ready !== 3'b000) bad++;
    end
    chk("stall_cycles_bad", 32'(bad), 32'd0);
    tx_full = 1'b0;
    #1;
    chk("stall_ready_after", 32'(req_ready), 32'b001);
    step();
    chk("stall_we", 32'(out_we), 32'd1);
    chk("stall_data", out_data, 32'h5A);
    req_valid = '0;
    repeat (5) step();
    chk("drop_keep_grant", 32'(grant), 32'b001);
    chk("drop_no_we", 32'(out_we), 32'd0);
    chk("drop_hold_data", out_data, 32'h5A);
    req_valid = 3'b001;
    req_data  = 24'h00000A;
    #1;
    chk("raise_ready", 32'(req_ready), 32'b001);
    step();
    chk("raise_we", 32'(out_we), 32'd1);
    chk("raise_data", out_data, 32'h0A);
    req_valid = '0;
    step();
    chk("raise_release", 32'(grant), 32'd0);

    // Reset right after req1 accepts 0x55.
    do_reset();
    req_valid = 3'b010;
    req_data  = 24'h005500;
    step();
    step();
    chk("mr_grant", 32'(grant), 32'b010);
    step();
    chk("mr_we_pre", 32'(out_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("mr_we", 32'(out_we), 32'd0);
    chk("mr_grant0", 32'(grant), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_ready", 32'(req_ready), 32'd0);
    chk("mr_data", out_data, 32'd0);
    step();
    chk("mr_we_hold", 32'(out_we), 32'd0);
    rst = 1'b0;
    req_valid = 3'b111;
    req_data  = 24'h333231;
    step();
    step();
    chk("mr_post_grant", 32'(grant), 32'b001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
